ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline stage of the MIPS core. It sits directly downstream of the ALU. Each cycle it captures the ALU result and zero flag together with the EX-stage side information, and presents them to the memory stage. It also resolves beq/bne, issues a one-cycle redirect to fetch, self-squashes the one wrong-path instruction that follows a taken branch, and supports stall and flush.

## Interface
Parameters:
- W, 32, datapath width (ALU result, store data, PC).
- RW, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  EX holds a real instruction.
- ex_saida  in  W  ALU result.
- ex_zero  in  1  ALU zero flag.
- ex_store_data  in  W  rt value for sw.
- ex_rd  in  RW  destination register.
- ex_pc4  in  W  PC+4 of the EX instruction.
- ex_offset  in  W  sign-extended branch immediate, in words.
- ex_ctrl  in  6  {branch_ne, branch_eq, mem_to_reg, mem_write, mem_read, reg_write}.
- stall  in  1  MEM busy; hold the register.
- flush  in  1  insert a bubble.
- ex_ready  out  1  EX contents accepted this cycle (= !stall).
- mem_valid  out  1  registered instruction is valid.
- mem_alu_out  out  W  registered ALU result.
- mem_store_data  out  W  registered rt value.
- mem_rd  out  RW  registered destination register.
- mem_ctrl  out  4  registered {mem_to_reg, mem_write, mem_read, reg_write}.
- br_taken  out  1  redirect pulse.
- br_target  out  W  redirect address.
- fwd_valid, fwd_rd, fwd_data  out  1/RW/W  forwarding source (see Configuration).

## Operation
- Priority: reset > flush > stall > capture.
- Capture happens when !stall and !flush.
  - Registers ex_* into mem_*.
  - mem_valid = ex_valid && state==RUN.
- Write to $0 is suppressed: if ex_rd==0, the captured reg_write is 0.
- Bubble (flush, or squash): mem_valid=0 and mem_ctrl=0. Data fields may hold any value.
- Stall without flush: all mem_* outputs hold their values.
- Branch resolution at capture of a valid RUN instruction:
  - taken = (branch_eq && ex_zero) || (branch_ne && !ex_zero).
  - br_target = ex_pc4 + (ex_offset << 2), modulo 2^W. It is registered with the instruction.
- FSM:
  - RUN: a capture with taken goes to SQUASH.
  - SQUASH: the next capture records a bubble regardless of ex_valid, then returns to RUN.
  - Flush in either state returns to RUN.
  - Stall holds the state.
- br_taken is high for exactly one cycle: the cycle after the taken branch is captured. It does not re-assert while a stall holds the branch in place.
- Branches carry no memory/writeback effect; mem_ctrl is as decoded (normally 0).

## Timing
- Latency: one cycle from EX inputs to mem_* and br_taken.
- Reset values: all outputs 0, state=RUN. ex_ready follows stall combinationally.
- Flush and stall in the same cycle: the bubble is inserted (flush wins).
- Flush in the cycle br_taken is high: state goes to RUN and no squash occurs.
- Reset asserted mid-stall or in SQUASH: immediate clear. The first capture after reset is RUN.
- ex_offset negative: target wraps modulo 2^W.

## Configuration
- EXMEM_FWD_EN defined:
  - fwd_valid = mem_valid && mem_ctrl.reg_write && !mem_ctrl.mem_to_reg.
  - fwd_rd = mem_rd.
  - fwd_data = mem_alu_out.
  - Consumed by EX forwarding muxes.
- EXMEM_FWD_EN undefined: fwd_* ports are still present and tied to 0.

## Structure
- Shared package mips_pkg holds:
  - ctrl bit-index constants (REG_WRITE=0 … BRANCH_NE=5);
  - the FSM state enum {RUN, SQUASH};
  - W and RW defaults.
- One sub-module is natural: branch_unit, a combinational taken/target computation, reusable if branches move to ID.

## Test plan
- Reset: rst_n low mid-stream -> every output 0 immediately; capture ex_saida=0x0000_0010, rd=8, reg_write -> next cycle mem_alu_out=0x10, mem_rd=8, mem_valid=1.
- beq, ex_zero=1, pc4=0x0040_0008, offset=-2 -> br_taken=1 for one cycle, br_target=0x0040_0000; next captured instruction gives mem_valid=0; the one after is valid.
- bne, ex_zero=1 -> no br_taken; following instruction is not squashed.
- stall held 3 cycles after a taken-branch capture -> outputs frozen, br_taken high only in the first cycle; the squash applies to the first post-stall capture.
- flush and stall together -> mem_valid=0, mem_ctrl=0; ex_rd=0 with reg_write=1 -> mem_ctrl.reg_write=0.
- With EXMEM_FWD_EN: add result 0x1234, rd=5 -> fwd_valid=1, fwd_rd=5, fwd_data=0x1234; lw -> fwd_valid=0; without the macro -> fwd_* stay 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: default widths, ex_ctrl bit positions
// and the EX/MEM squash FSM state encoding.
package mips_pkg;

    localparam int unsigned DEF_W   = 32;
    localparam int unsigned DEF_RW  = 5;
    localparam int unsigned CTRL_W  = 6;
    localparam int unsigned MCTRL_W = 4;

    // ex_ctrl bit indices; the low four bits are what the memory stage sees
    localparam int unsigned REG_WRITE  = 0;
    localparam int unsigned MEM_READ   = 1;
    localparam int unsigned MEM_WRITE  = 2;
    localparam int unsigned MEM_TO_REG = 3;
    localparam int unsigned BRANCH_EQ  = 4;
    localparam int unsigned BRANCH_NE  = 5;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } exmem_state_e;

endpackage

// File: rtl/branch_unit.sv
// Combinational beq/bne resolution and branch-target computation.
// Ports:
//   i_branch_eq, i_branch_ne : decoded branch kind
//   i_zero                   : ALU zero flag (rs == rt)
//   i_pc4, i_offset          : PC+4 and sign-extended word offset
//   o_taken_c                : branch condition holds
//   o_target_c               : pc4 + offset*4, modulo 2^W
module branch_unit #(
    parameter int unsigned W = 32
) (
    input  logic         i_branch_eq,
    input  logic         i_branch_ne,
    input  logic         i_zero,
    input  logic [W-1:0] i_pc4,
    input  logic [W-1:0] i_offset,
    output logic         o_taken_c,
    output logic [W-1:0] o_target_c
);

    assign o_taken_c  = (i_branch_eq && i_zero) || (i_branch_ne && !i_zero);
    assign o_target_c = W'(i_pc4 + W'(i_offset << 2));

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register. Captures the ALU result and EX side information,
// resolves beq/bne, pulses a one-cycle redirect and squashes the single
// wrong-path instruction that follows a taken branch. Supports stall/flush.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   ex_*                              : EX-stage instruction and ALU results
//   stall, flush                      : hold register / insert bubble
//   ex_ready                          : combinational, = !stall
//   mem_valid/alu_out/store_data/rd/ctrl : registered MEM-stage view
//   br_taken, br_target               : registered redirect pulse and address
//   fwd_valid, fwd_rd, fwd_data       : forwarding source for EX
// Build option: EXMEM_FWD_EN enables the forwarding outputs; otherwise they
// are tied to 0.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned RW = DEF_RW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [W-1:0]       ex_saida,
    input  logic               ex_zero,
    input  logic [W-1:0]       ex_store_data,
    input  logic [RW-1:0]      ex_rd,
    input  logic [W-1:0]       ex_pc4,
    input  logic [W-1:0]       ex_offset,
    input  logic [CTRL_W-1:0]  ex_ctrl,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_ready,
    output logic               mem_valid,
    output logic [W-1:0]       mem_alu_out,
    output logic [W-1:0]       mem_store_data,
    output logic [RW-1:0]      mem_rd,
    output logic [MCTRL_W-1:0] mem_ctrl,
    output logic               br_taken,
    output logic [W-1:0]       br_target,
    output logic               fwd_valid,
    output logic [RW-1:0]      fwd_rd,
    output logic [W-1:0]       fwd_data
);

    exmem_state_e       r_state;
    exmem_state_e       w_state_nxt;

    logic               r_valid;
    logic [W-1:0]       r_alu;
    logic [W-1:0]       r_sd;
    logic [RW-1:0]      r_rd;
    logic [MCTRL_W-1:0] r_ctrl;
    logic               r_br_taken;
    logic [W-1:0]       r_br_target;

    logic               w_valid_nxt;
    logic [W-1:0]       w_alu_nxt;
    logic [W-1:0]       w_sd_nxt;
    logic [RW-1:0]      w_rd_nxt;
    logic [MCTRL_W-1:0] w_ctrl_nxt;
    logic               w_br_taken_nxt;
    logic [W-1:0]       w_br_target_nxt;

    logic               w_taken;
    logic [W-1:0]       w_target;
    logic               w_live;

    branch_unit #(.W(W)) u_branch (
        .i_branch_eq (ex_ctrl[BRANCH_EQ]),
        .i_branch_ne (ex_ctrl[BRANCH_NE]),
        .i_zero      (ex_zero),
        .i_pc4       (ex_pc4),
        .i_offset    (ex_offset),
        .o_taken_c   (w_taken),
        .o_target_c  (w_target)
    );

    // Instruction survives capture only when real and not on the wrong path
    assign w_live   = ex_valid && (r_state == RUN);
    assign ex_ready = !stall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register contents; flush beats stall beats capture
    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_alu_nxt       = r_alu;
        w_sd_nxt        = r_sd;
        w_rd_nxt        = r_rd;
        w_ctrl_nxt      = r_ctrl;
        w_br_taken_nxt  = 1'b0;
        w_br_target_nxt = r_br_target;

        if (flush) begin
            w_state_nxt = RUN;
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = '0;
        end else if (!stall) begin
            w_valid_nxt     = w_live;
            w_alu_nxt       = ex_saida;
            w_sd_nxt        = ex_store_data;
            w_rd_nxt        = ex_rd;
            w_br_target_nxt = w_target;
            // $0 is hard-wired: never let a write to it reach writeback
            w_ctrl_nxt      = w_live ? {ex_ctrl[MEM_TO_REG], ex_ctrl[MEM_WRITE],
                                        ex_ctrl[MEM_READ],
                                        ex_ctrl[REG_WRITE] && (ex_rd != '0)}
                                     : '0;
            w_br_taken_nxt  = w_live && w_taken;
            w_state_nxt     = (w_live && w_taken) ? SQUASH : RUN;
        end
    end

    // MEM-stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu       <= '0;
            r_sd        <= '0;
            r_rd        <= '0;
            r_ctrl      <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_alu       <= w_alu_nxt;
            r_sd        <= w_sd_nxt;
            r_rd        <= w_rd_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_br_taken  <= w_br_taken_nxt;
            r_br_target <= w_br_target_nxt;
        end
    end

    assign mem_valid      = r_valid;
    assign mem_alu_out    = r_alu;
    assign mem_store_data = r_sd;
    assign mem_rd         = r_rd;
    assign mem_ctrl       = r_ctrl;
    assign br_taken       = r_br_taken;
    assign br_target      = r_br_target;

`ifdef EXMEM_FWD_EN
    logic r_fwd_valid;

    // Loads are excluded: their data is not known until after MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_valid <= 1'b0;
        end else begin
            r_fwd_valid <= w_valid_nxt && w_ctrl_nxt[REG_WRITE]
                           && !w_ctrl_nxt[MEM_TO_REG];
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_alu;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a vector table applied through a
// scoreboard queue, plus hand-written reset and stall-after-branch sequences.
module tb_ex_mem_stage;

    localparam logic [5:0] CR   = 6'b000001;
    localparam logic [5:0] CLW  = 6'b001011;
    localparam logic [5:0] CSW  = 6'b000100;
    localparam logic [5:0] CBEQ = 6'b010000;
    localparam logic [5:0] CBNE = 6'b100000;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_saida;
    logic        ex_zero;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic [31:0] ex_pc4;
    logic [31:0] ex_offset;
    logic [5:0]  ex_ctrl;
    logic        stall;
    logic        flush;
    logic        ex_ready;
    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic [3:0]  mem_ctrl;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] saida;
        logic        zero;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] off;
        logic [5:0]  ctrl;
        logic        stall;
        logic        flush;
        logic        e_valid;
        logic [3:0]  e_ctrl;
        logic        e_br;
        logic        c_data;
        logic [31:0] e_alu;
        logic [31:0] e_sd;
        logic [4:0]  e_rd;
        logic        c_tgt;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t q_exp[$];
    vec_t tbl[21];

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_saida       (ex_saida),
        .ex_zero        (ex_zero),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_pc4         (ex_pc4),
        .ex_offset      (ex_offset),
        .ex_ctrl        (ex_ctrl),
        .stall          (stall),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .mem_valid      (mem_valid),
        .mem_alu_out    (mem_alu_out),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_ctrl       (mem_ctrl),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t row(input logic v, input logic [31:0] saida,
                                 input logic z, input logic [31:0] sd,
                                 input logic [4:0] rd, input logic [31:0] pc4,
                                 input logic [31:0] off, input logic [5:0] ctrl,
                                 input logic st, input logic fl,
                                 input logic ev, input logic [3:0] ectrl,
                                 input logic ebr, input logic cdata,
                                 input logic [31:0] etgt);
        vec_t r;
        r.valid = v;     r.saida = saida; r.zero = z;  r.sd = sd;
        r.rd = rd;       r.pc4 = pc4;     r.off = off; r.ctrl = ctrl;
        r.stall = st;    r.flush = fl;
        r.e_valid = ev;  r.e_ctrl = ectrl; r.e_br = ebr; r.c_data = cdata;
        r.e_alu = saida; r.e_sd = sd;     r.e_rd = rd;
        r.c_tgt = ebr;   r.e_tgt = etgt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_head();
        vec_t e;
        logic e_fv;
        if (q_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard act=empty exp=entry");
            return;
        end
        e = q_exp.pop_front();
        chk("mem_valid", 32'(mem_valid), 32'(e.e_valid));
        chk("mem_ctrl",  32'(mem_ctrl),  32'(e.e_ctrl));
        chk("br_taken",  32'(br_taken),  32'(e.e_br));
        if (e.c_data) begin
            chk("mem_alu_out",    mem_alu_out,    e.e_alu);
            chk("mem_store_data", mem_store_data, e.e_sd);
            chk("mem_rd",         32'(mem_rd),    32'(e.e_rd));
        end
        if (e.c_tgt) chk("br_target", br_target, e.e_tgt);
`ifdef EXMEM_FWD_EN
        e_fv = e.e_valid && e.e_ctrl[0] && !e.e_ctrl[3];
        chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
        if (e_fv) begin
            chk("fwd_rd",   32'(fwd_rd), 32'(e.e_rd));
            chk("fwd_data", fwd_data,    e.e_alu);
        end
`else
        e_fv = 1'b0;
        chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
        chk("fwd_rd",    32'(fwd_rd),    32'd0);
        chk("fwd_data",  fwd_data,       32'd0);
`endif
    endtask

    // Called at a negedge: drive, queue the expectation, check after the edge
    task automatic apply(input vec_t v);
        ex_valid = v.valid;  ex_saida = v.saida; ex_zero = v.zero;
        ex_store_data = v.sd; ex_rd = v.rd;      ex_pc4 = v.pc4;
        ex_offset = v.off;   ex_ctrl = v.ctrl;   stall = v.stall;
        flush = v.flush;
        q_exp.push_back(v);
        #1;
        chk("ex_ready", 32'(ex_ready), 32'(!v.stall));
        @(posedge clk);
        #1;
        check_head();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid),   32'd0);
        chk({tag, "_alu"},   mem_alu_out,      32'd0);
        chk({tag, "_sd"},    mem_store_data,   32'd0);
        chk({tag, "_rd"},    32'(mem_rd),      32'd0);
        chk({tag, "_ctrl"},  32'(mem_ctrl),    32'd0);
        chk({tag, "_br"},    32'(br_taken),    32'd0);
        chk({tag, "_tgt"},   br_target,        32'd0);
        chk({tag, "_fwdv"},  32'(fwd_valid),   32'd0);
        chk({tag, "_fwdrd"}, 32'(fwd_rd),      32'd0);
        chk({tag, "_fwdd"},  fwd_data,         32'd0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_saida = '0; ex_zero = 1'b0; ex_store_data = '0;
        ex_rd = '0; ex_pc4 = '0; ex_offset = '0; ex_ctrl = '0;
        stall = 1'b0; flush = 1'b0;

        //             v  saida         z  sd            rd  pc4           off           ctrl st fl  ev ectrl    br cd tgt
        tbl[0]  = row(1, 32'h10,       0, 32'hAAAA,     8,  0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[1]  = row(1, 32'h100,      0, 0,            9,  0,            0,            CLW, 0, 0,  1, 4'b1011, 0, 1, 0);
        tbl[2]  = row(1, 32'h200,      0, 32'hDEADBEEF, 0,  0,            0,            CSW, 0, 0,  1, 4'b0100, 0, 1, 0);
        tbl[3]  = row(1, 32'h3,        0, 0,            0,  0,            0,            CR,  0, 0,  1, 4'b0000, 0, 1, 0);
        tbl[4]  = row(1, 32'h0,        1, 0,            0,  32'h00400008, 32'hFFFFFFFE, CBEQ,0, 0,  1, 4'b0000, 1, 1, 32'h00400000);
        tbl[5]  = row(1, 32'h33,       0, 0,            3,  0,            0,            CR,  0, 0,  0, 4'b0000, 0, 0, 0);
        tbl[6]  = row(1, 32'h44,       0, 0,            4,  0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[7]  = row(1, 32'h0,        1, 0,            0,  32'h200,      32'h10,       CBNE,0, 0,  1, 4'b0000, 0, 1, 0);
        tbl[8]  = row(1, 32'h66,       0, 0,            6,  0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[9]  = row(1, 32'h0,        0, 0,            0,  32'h100,      32'h4,        CBNE,0, 0,  1, 4'b0000, 1, 1, 32'h00000110);
        tbl[10] = row(0, 32'h77,       0, 0,            7,  0,            0,            CR,  0, 0,  0, 4'b0000, 0, 0, 0);
        tbl[11] = row(1, 32'h77,       0, 0,            7,  0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[12] = row(1, 32'h0,        0, 0,            0,  32'h300,      32'h8,        CBEQ,0, 0,  1, 4'b0000, 0, 1, 0);
        tbl[13] = row(1, 32'h55,       0, 0,            5,  0,            0,            CR,  1, 1,  0, 4'b0000, 0, 0, 0);
        tbl[14] = row(1, 32'h99,       0, 0,            10, 0,            0,            CR,  1, 0,  0, 4'b0000, 0, 0, 0);
        tbl[15] = row(0, 32'h0,        0, 0,            0,  0,            0,            6'd0,0, 0,  0, 4'b0000, 0, 0, 0);
        tbl[16] = row(1, 32'h0,        1, 0,            0,  32'hFFFFFFF0, 32'h8,        CBEQ,0, 0,  1, 4'b0000, 1, 1, 32'h00000010);
        tbl[17] = row(1, 32'h88,       0, 0,            11, 0,            0,            CR,  0, 1,  0, 4'b0000, 0, 0, 0);
        tbl[18] = row(1, 32'hBB,       0, 0,            11, 0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[19] = row(1, 32'h1234,     0, 0,            5,  0,            0,            CR,  0, 0,  1, 4'b0001, 0, 1, 0);
        tbl[20] = row(1, 32'h500,      0, 0,            5,  0,            0,            CLW, 0, 0,  1, 4'b1011, 0, 1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table
        for (int i = 0; i < 21; i++) apply(tbl[i]);

        // Taken branch held by a 3-cycle stall: pulse once, squash after stall
        apply(row(1, 32'hABC, 1, 32'h5, 0, 32'h00400008, 32'hFFFFFFFE, CBEQ, 0, 0,
                  1, 4'b0000, 1, 1, 32'h00400000));
        for (int k = 0; k < 3; k++) begin
            v = row(1, 32'h77, 0, 0, 7, 0, 0, CR, 1, 0, 1, 4'b0000, 0, 1, 0);
            v.e_alu = 32'hABC; v.e_sd = 32'h5; v.e_rd = 5'd0;
            v.c_tgt = 1'b1;    v.e_tgt = 32'h00400000;
            apply(v);
        end
        apply(row(1, 32'h77, 0, 0, 7, 0, 0, CR, 0, 0, 0, 4'b0000, 0, 0, 0));
        apply(row(1, 32'h78, 0, 0, 7, 0, 0, CR, 0, 0, 1, 4'b0001, 0, 1, 0));

        // Reset mid-stall while in SQUASH: immediate clear, first capture runs
        apply(row(1, 32'h0, 1, 0, 0, 32'h1000, 32'h1, CBEQ, 0, 0,
                  1, 4'b0000, 1, 1, 32'h00001004));
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(row(1, 32'h10, 0, 0, 8, 0, 0, CR, 0, 0, 1, 4'b0001, 0, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
